// File: rtl/ray_config_pkg.sv
// Shared register map, control/status bit positions and sequencer states
// for the ray-tracer configuration block.
package ray_config_pkg;

  localparam int BUS_ID_WIDTH = 4;

  // Word offsets inside the 32-word config window
  localparam logic [4:0] OFF_CONTROL    = 5'h00;
  localparam logic [4:0] OFF_STATUS     = 5'h00;
  localparam logic [4:0] OFF_FRAME_ADDR = 5'h03;
  localparam logic [4:0] OFF_CAMERA     = 5'h04;
  localparam logic [4:0] OFF_WIDTH      = 5'h10;
  localparam logic [4:0] OFF_HEIGHT     = 5'h11;

  localparam int CTRL_START_BIT     = 0;
  localparam int CTRL_NORMALIZE_BIT = 5;
  localparam int STATUS_READY_BIT   = 1;

  typedef enum logic [2:0] {
    IDLE,
    WRITE_CFG,
    READ_STATUS,
    WAIT_STATUS,
    START,
    WAIT_DONE,
    FINISH
  } seq_state_e;

endpackage

// File: rtl/memory_bus.sv
// Request/response memory bus: ms* is master-to-slave, sm* is slave-to-master.
interface MemoryBus #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 24
) ();
  logic                                    msValid;
  logic [ADDRESS_WIDTH-1:0]                msAddress;
  logic                                    msWrite;
  logic [DATA_WIDTH-1:0]                   msData;
  logic [ray_config_pkg::BUS_ID_WIDTH-1:0] msID;
  logic                                    msTaken;
  logic                                    smValid;
  logic [DATA_WIDTH-1:0]                   smData;
  logic [ray_config_pkg::BUS_ID_WIDTH-1:0] smID;
  logic                                    smTaken;

  modport Master (
    output msValid, msAddress, msWrite, msData, msID, smTaken,
    input  msTaken, smValid, smData, smID
  );

  modport Slave (
    input  msValid, msAddress, msWrite, msData, msID, smTaken,
    output msTaken, smValid, smData, smID
  );
endinterface

// File: rtl/render_sequencer_bus_write_port.sv
// Single-outstanding bus request port: captures a request when free and
// holds valid/address/data/direction stable until the slave takes it.
module bus_write_port #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 24
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_i,
  input  logic                     write_i,
  input  logic [ADDRESS_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]    data_i,
  input  logic                     taken_i,
  output logic                     valid_o,
  output logic                     write_o,
  output logic [ADDRESS_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0]    data_o,
  output logic                     busy_o,
  output logic                     done_o
);

  logic                     valid_q, valid_d;
  logic                     write_q, write_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;

  // Load a new request only when nothing is outstanding; clear on handshake
  always_comb begin
    valid_d = valid_q;
    write_d = write_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (valid_q) begin
      if (taken_i) valid_d = 1'b0;
    end else if (req_i) begin
      valid_d = 1'b1;
      write_d = write_i;
      addr_d  = addr_i;
      data_d  = data_i;
    end
  end

  // Request registers; reset drops valid immediately
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign write_o = write_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign busy_o  = valid_q;
  assign done_o  = valid_q & taken_i;

endmodule

// File: rtl/render_sequencer.sv
// Frame render sequencer: snapshots camera/frame settings, programs the
// ray-tracer config block, polls until ready, starts it and waits for done.
//
// state       | meaning
// IDLE        | waiting for a host request
// WRITE_CFG   | writing frame address, camera vectors, width, height
// READ_STATUS | issuing a read of the status word
// WAIT_STATUS | waiting for our status response
// START       | writing the start/normalize control word
// WAIT_DONE   | ray tracer busy, waiting for its interrupt
// FINISH      | one-cycle frameDone pulse, display buffer flips
module render_sequencer
  import ray_config_pkg::*;
#(
  parameter int                       POSITION_WIDTH = 16,
  parameter int                       DATA_WIDTH     = 24,
  parameter int                       ADDRESS_WIDTH  = 32,
  parameter int                       SEQ_ID         = 0,
  parameter logic [ADDRESS_WIDTH-1:0] CONFIG_ADDRESS = '0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          request,
  output logic                          accepted,
  input  logic [2:0][POSITION_WIDTH-1:0] cameraQ,
  input  logic [2:0][POSITION_WIDTH-1:0] cameraV,
  input  logic [2:0][POSITION_WIDTH-1:0] cameraX,
  input  logic [2:0][POSITION_WIDTH-1:0] cameraY,
  input  logic [ADDRESS_WIDTH-1:0]      frameBase0,
  input  logic [ADDRESS_WIDTH-1:0]      frameBase1,
  input  logic [11:0]                   width,
  input  logic [11:0]                   height,
  input  logic                          normalize,
  input  logic                          interrupt,
  output logic                          frameDone,
  output logic                          displayBuffer,
  output logic                          idle,
  MemoryBus.Master                      bus
);

  seq_state_e state_q, state_d;
  logic [4:0] off_q, off_d;
  logic       disp_q, disp_d;

  // Snapshot taken at acceptance; camera words ordered Q0..Q2,V0..,X0..,Y0..Y2
  logic [11:0][POSITION_WIDTH-1:0] cam_q;
  logic [ADDRESS_WIDTH-9:0]        frame_q;
  logic [11:0]                     width_q, height_q;
  logic                            norm_q, target_q;

  logic [3:0]                cam_sel;
  logic [POSITION_WIDTH-1:0] cam_word;
  logic [DATA_WIDTH-1:0]     cfg_data;

  logic                  port_req, port_write, port_busy, port_done;
  logic [4:0]            port_offset;
  logic [DATA_WIDTH-1:0] port_data;
  logic                  sm_taken;

  // Data word for the current config offset
  always_comb begin
    cam_sel  = 4'(off_q - OFF_CAMERA);
    cam_word = (cam_sel < 4'd12) ? cam_q[cam_sel] : '0;
    case (off_q)
      OFF_FRAME_ADDR: cfg_data = DATA_WIDTH'(frame_q);
      OFF_WIDTH:      cfg_data = DATA_WIDTH'(width_q);
      OFF_HEIGHT:     cfg_data = DATA_WIDTH'(height_q);
      default:        cfg_data = {{(DATA_WIDTH-POSITION_WIDTH){cam_word[POSITION_WIDTH-1]}}, cam_word};
    endcase
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    disp_d      = disp_q;
    accepted    = 1'b0;
    frameDone   = 1'b0;
    sm_taken    = 1'b0;
    port_req    = 1'b0;
    port_write  = 1'b1;
    port_offset = off_q;
    port_data   = cfg_data;
    case (state_q)
      IDLE: begin
        if (request && reset) begin
          accepted = 1'b1;
          off_d    = OFF_FRAME_ADDR;
          state_d  = WRITE_CFG;
        end
      end
      WRITE_CFG: begin
        port_req = !port_busy;
        if (port_done) begin
          if (off_q == OFF_HEIGHT) state_d = READ_STATUS;
          else off_d = off_q + 5'd1;
        end
      end
      READ_STATUS: begin
        port_req    = !port_busy;
        port_write  = 1'b0;
        port_offset = OFF_STATUS;
        port_data   = '0;
        if (port_done) state_d = WAIT_STATUS;
      end
      WAIT_STATUS: begin
        sm_taken = 1'b1;
        if (bus.smValid && bus.smID == BUS_ID_WIDTH'(SEQ_ID))
          state_d = bus.smData[STATUS_READY_BIT] ? START : READ_STATUS;
      end
      START: begin
        port_req    = !port_busy;
        port_offset = OFF_CONTROL;
        port_data   = '0;
        port_data[CTRL_START_BIT]     = 1'b1;
        port_data[CTRL_NORMALIZE_BIT] = norm_q;
        if (port_done) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (interrupt) begin
          disp_d  = target_q;
          state_d = FINISH;
        end
      end
      FINISH: begin
        frameDone = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, offset counter and display buffer registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      off_q   <= OFF_FRAME_ADDR;
      disp_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      disp_q  <= disp_d;
    end
  end

  // Input snapshot on acceptance; target is the buffer not on display
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cam_q    <= '0;
      frame_q  <= '0;
      width_q  <= '0;
      height_q <= '0;
      norm_q   <= 1'b0;
      target_q <= 1'b0;
    end else if (accepted) begin
      cam_q    <= {cameraY, cameraX, cameraV, cameraQ};
      frame_q  <= disp_q ? frameBase0[ADDRESS_WIDTH-1:8] : frameBase1[ADDRESS_WIDTH-1:8];
      width_q  <= width;
      height_q <= height;
      norm_q   <= normalize;
      target_q <= ~disp_q;
    end
  end

  bus_write_port #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_port (
    .clock  (clock),
    .reset  (reset),
    .req_i  (port_req),
    .write_i(port_write),
    .addr_i (CONFIG_ADDRESS + ADDRESS_WIDTH'(port_offset)),
    .data_i (port_data),
    .taken_i(bus.msTaken),
    .valid_o(bus.msValid),
    .write_o(bus.msWrite),
    .addr_o (bus.msAddress),
    .data_o (bus.msData),
    .busy_o (port_busy),
    .done_o (port_done)
  );

  assign bus.msID        = BUS_ID_WIDTH'(SEQ_ID);
  assign bus.smTaken     = sm_taken;
  assign displayBuffer   = disp_q;
  assign idle            = (state_q == IDLE);

endmodule
